mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle main controller for the MIPS core. It sequences the PC register, IR, register file, ALU and data memory through FETCH/DECODE/EXEC/MEM/WB states and generates every datapath enable and select. It sits beside the PC/NPC datapath and drives the PC write enable and the next-PC source select. A ready handshake on data memory allows it to stall on slow memory.

Parameters:
CNT_W, 32, width of retired-instruction counter; used only when INSTR_CNT_EN is defined.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
opcode  in  6  IR[31:26]; stable from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU equality result (rs==rt)
dmem_ready  in  1  data memory done; sampled in MEM
pc_we  out  1  PC load enable
npc_sel  out  2  00 pc+4, 01 branch target, 10 j/jal target, 11 rs (jr)
ir_we  out  1  IR load enable
reg_we  out  1  register file write
reg_dst  out  2  00 rt, 01 rd, 10 $31
wd_sel  out  2  00 ALU, 01 memory, 10 pc+4
alu_src  out  1  0 register rt, 1 extended immediate
alu_op  out  3  000 add, 001 sub, 010 or, 011 lui (imm<<16)
ext_op  out  1  1 sign-extend, 0 zero-extend
dmem_req  out  1  memory access request
dmem_we  out  1  memory write qualifier
illegal  out  1  one-cycle pulse: unsupported instruction
state  out  3  current state encoding, for debug

Behaviour:
- Reset is synchronous, active-high; clock is clk. While reset=1, the next state is FETCH and all outputs are forced to 0, including during MEM. After reset, state=FETCH (000).
- Encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Unused codes go to FETCH.
- Supported instructions: addu(0/21h), subu(0/23h), jr(0/08h), ori(0Dh), lui(0Fh), lw(23h), sw(2Bh), beq(04h), j(02h), jal(03h).
- Outputs are Moore/Mealy combinational from state plus opcode/funct/zero. Any output not listed for a state is 0.
- FETCH: ir_we=1, pc_we=1, npc_sel=00. Next state is DECODE.
- DECODE:
  - j: pc_we=1, npc_sel=10, then FETCH.
  - jal: j outputs plus reg_we=1, reg_dst=10, wd_sel=10, then FETCH.
  - jr: pc_we=1, npc_sel=11, then FETCH.
  - Unsupported opcode or funct: illegal=1, then FETCH. The instruction acts as a nop.
  - All other instructions go to EXEC.
- EXEC:
  - addu: alu_op=000. subu: alu_op=001.
  - ori: alu_src=1, ext_op=0, alu_op=010.
  - lui: alu_src=1, alu_op=011.
  - lw/sw: alu_src=1, ext_op=1, alu_op=000.
  - beq: alu_op=001, npc_sel=01, pc_we=zero.
  - Next state: beq goes to FETCH, lw/sw go to MEM, all others go to WB.
- MEM: dmem_req=1, dmem_we=(sw), EXEC ALU controls held.
  - Stays in MEM while dmem_ready=0.
  - On dmem_ready=1: sw goes to FETCH, lw goes to WB.
  - dmem_ready outside MEM is ignored.
- WB: reg_we=1, with EXEC ALU controls held.
  - R-type: reg_dst=01, wd_sel=00. ori/lui: reg_dst=00, wd_sel=00. lw: reg_dst=00, wd_sel=01.
  - Next state is FETCH.
- Cycle counts with zero-wait memory:
  - j/jal/jr/illegal: 2.
  - beq: 3.
  - R-type/ori/lui/sw: 4.
  - lw: 5.
  - Each MEM wait cycle adds 1.
- pc_we is asserted in at most one state per instruction after FETCH. No register write occurs on beq, j, jr or sw.

Optional Feature:
INSTR_CNT_EN
- Defined: adds output retired [CNT_W-1:0], reset to 0. It increments by 1 on every transition into FETCH from a completing state (DECODE for j/jal/jr, EXEC, MEM, WB). Illegal instructions are not counted. It wraps modulo 2^CNT_W.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert reset 2 cycles -> state=0; pc_we=0, reg_we=0, dmem_req=0 during reset. The first post-reset cycle shows ir_we=1, pc_we=1.
- addu (opcode 00, funct 21h) -> states 0,1,2,4,0. WB cycle shows reg_we=1, reg_dst=01, wd_sel=00. pc_we is high only in FETCH.
- lw (23h), dmem_ready low 3 cycles then high -> MEM held 4 cycles with dmem_req=1, dmem_we=0. Then WB with wd_sel=01, reg_dst=00. Total 8 cycles.
- beq (04h) with zero=1 -> EXEC shows pc_we=1, npc_sel=01. With zero=0 -> pc_we=0 in EXEC. Both return to FETCH after 3 cycles.
- jal (03h) -> DECODE shows pc_we=1, npc_sel=10, reg_we=1, reg_dst=10, wd_sel=10. Back in FETCH next cycle. With INSTR_CNT_EN, retired increments by 1.
- sw with dmem_ready=0, reset asserted in 2nd MEM cycle -> dmem_req=0 that cycle, state=FETCH next. Opcode 3Fh -> illegal=1 for exactly one cycle in DECODE, no reg_we/pc_we beyond FETCH.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXEC/MEM/WB sequencing and datapath controls.
// Optional retired-instruction counter enabled by defining INSTR_CNT_EN.
module mc_ctrl
`ifdef INSTR_CNT_EN
#(
   parameter int unsigned CNT_W = 32
)
`endif
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       dmem_ready,
   output logic       pc_we,
   output logic [1:0] npc_sel,
   output logic       ir_we,
   output logic       reg_we,
   output logic [1:0] reg_dst,
   output logic [1:0] wd_sel,
   output logic       alu_src,
   output logic [2:0] alu_op,
   output logic       ext_op,
   output logic       dmem_req,
   output logic       dmem_we,
   output logic       illegal,
   output logic [2:0] state
`ifdef INSTR_CNT_EN
   ,
   output logic [CNT_W-1:0] retired
`endif
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   localparam logic [1:0] NPC_PC4 = 2'b00;
   localparam logic [1:0] NPC_BR  = 2'b01;
   localparam logic [1:0] NPC_JMP = 2'b10;
   localparam logic [1:0] NPC_RS  = 2'b11;

   localparam logic [1:0] DST_RT  = 2'b00;
   localparam logic [1:0] DST_RD  = 2'b01;
   localparam logic [1:0] DST_RA  = 2'b10;

   localparam logic [1:0] WD_ALU  = 2'b00;
   localparam logic [1:0] WD_MEM  = 2'b01;
   localparam logic [1:0] WD_PC4  = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b010;
   localparam logic [2:0] ALU_LUI = 3'b011;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_e;

   typedef enum logic [3:0] {
      I_ILL, I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL
   } instr_e;

   state_e state_q, state_d;
   instr_e instr_c;
   logic       alu_src_c;
   logic [2:0] alu_op_c;
   logic       ext_op_c;

   // Instruction classification from opcode/funct
   always_comb begin
      instr_c = I_ILL;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU: instr_c = I_ADDU;
               FN_SUBU: instr_c = I_SUBU;
               FN_JR:   instr_c = I_JR;
               default: instr_c = I_ILL;
            endcase
         end
         OP_ORI:  instr_c = I_ORI;
         OP_LUI:  instr_c = I_LUI;
         OP_LW:   instr_c = I_LW;
         OP_SW:   instr_c = I_SW;
         OP_BEQ:  instr_c = I_BEQ;
         OP_J:    instr_c = I_J;
         OP_JAL:  instr_c = I_JAL;
         default: instr_c = I_ILL;
      endcase
   end

   // ALU controls established in EXEC and held through MEM/WB
   always_comb begin
      alu_src_c = 1'b0;
      alu_op_c  = ALU_ADD;
      ext_op_c  = 1'b0;
      case (instr_c)
         I_SUBU: alu_op_c = ALU_SUB;
         I_ORI: begin
            alu_src_c = 1'b1;
            alu_op_c  = ALU_OR;
         end
         I_LUI: begin
            alu_src_c = 1'b1;
            alu_op_c  = ALU_LUI;
         end
         I_LW, I_SW: begin
            alu_src_c = 1'b1;
            ext_op_c  = 1'b1;
         end
         I_BEQ:   alu_op_c = ALU_SUB;
         default: alu_op_c = ALU_ADD;
      endcase
   end

   // Next state and control outputs; reset forces every output low
   always_comb begin
      state_d  = S_FETCH;
      pc_we    = 1'b0;
      npc_sel  = NPC_PC4;
      ir_we    = 1'b0;
      reg_we   = 1'b0;
      reg_dst  = DST_RT;
      wd_sel   = WD_ALU;
      alu_src  = 1'b0;
      alu_op   = ALU_ADD;
      ext_op   = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      illegal  = 1'b0;
      state    = 3'd0;
      if (!reset) begin
         state = state_q;
         case (state_q)
            S_FETCH: begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_DECODE;
            end
            S_DECODE: begin
               state_d = S_EXEC;
               case (instr_c)
                  I_J: begin
                     pc_we   = 1'b1;
                     npc_sel = NPC_JMP;
                     state_d = S_FETCH;
                  end
                  I_JAL: begin
                     pc_we   = 1'b1;
                     npc_sel = NPC_JMP;
                     reg_we  = 1'b1;
                     reg_dst = DST_RA;
                     wd_sel  = WD_PC4;
                     state_d = S_FETCH;
                  end
                  I_JR: begin
                     pc_we   = 1'b1;
                     npc_sel = NPC_RS;
                     state_d = S_FETCH;
                  end
                  I_ILL: begin
                     illegal = 1'b1;
                     state_d = S_FETCH;
                  end
                  default: state_d = S_EXEC;
               endcase
            end
            S_EXEC: begin
               alu_src = alu_src_c;
               alu_op  = alu_op_c;
               ext_op  = ext_op_c;
               if (instr_c == I_BEQ) begin
                  npc_sel = NPC_BR;
                  pc_we   = zero;
                  state_d = S_FETCH;
               end else if (instr_c == I_LW || instr_c == I_SW) begin
                  state_d = S_MEM;
               end else begin
                  state_d = S_WB;
               end
            end
            S_MEM: begin
               alu_src  = alu_src_c;
               alu_op   = alu_op_c;
               ext_op   = ext_op_c;
               dmem_req = 1'b1;
               dmem_we  = (instr_c == I_SW);
               if (!dmem_ready)            state_d = S_MEM;
               else if (instr_c == I_SW)   state_d = S_FETCH;
               else                        state_d = S_WB;
            end
            S_WB: begin
               alu_src = alu_src_c;
               alu_op  = alu_op_c;
               ext_op  = ext_op_c;
               reg_we  = 1'b1;
               if (instr_c == I_ADDU || instr_c == I_SUBU) begin
                  reg_dst = DST_RD;
               end
               if (instr_c == I_LW) begin
                  wd_sel = WD_MEM;
               end
               state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

`ifdef INSTR_CNT_EN
   logic [CNT_W-1:0] retired_q;
   logic             retire_c;

   // DECODE only returns to FETCH for jumps or illegal; illegal is not counted
   assign retire_c = (state_d == S_FETCH) &&
                     ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB) ||
                      ((state_q == S_DECODE) && (instr_c != I_ILL)));

   always_ff @(posedge clk) begin
      if (reset)         retired_q <= '0;
      else if (retire_c) retired_q <= retired_q + CNT_W'(1);
   end

   assign retired = retired_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction expected cycle sequences built from
// the instruction semantics, directed scenarios plus randomized instruction streams.
module tb_mc_ctrl;

   typedef struct packed {
      logic       pc_we;
      logic [1:0] npc_sel;
      logic       ir_we;
      logic       reg_we;
      logic [1:0] reg_dst;
      logic [1:0] wd_sel;
      logic       alu_src;
      logic [2:0] alu_op;
      logic       ext_op;
      logic       dmem_req;
      logic       dmem_we;
      logic       illegal;
      logic [2:0] state;
   } out_t;

   localparam logic [5:0] ADDU_FN = 6'h21, SUBU_FN = 6'h23, JR_FN = 6'h08;
   localparam logic [5:0] ORI = 6'h0D, LUI = 6'h0F, LW = 6'h23, SW = 6'h2B;
   localparam logic [5:0] BEQ = 6'h04, J = 6'h02, JAL = 6'h03;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode, funct;
   logic       zero, dmem_ready;
   logic       pc_we, ir_we, reg_we, alu_src, ext_op, dmem_req, dmem_we, illegal;
   logic [1:0] npc_sel, reg_dst, wd_sel;
   logic [2:0] alu_op, state;
`ifdef INSTR_CNT_EN
   logic [31:0] retired;
`endif

   int   errors = 0;
   int   checks = 0;
   int   model_cnt = 0;
   out_t exp_q[$];
   logic rdy_q[$];

   always #5 clk = ~clk;

   mc_ctrl dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .dmem_ready(dmem_ready), .pc_we(pc_we), .npc_sel(npc_sel), .ir_we(ir_we),
      .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src(alu_src),
      .alu_op(alu_op), .ext_op(ext_op), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .illegal(illegal), .state(state)
`ifdef INSTR_CNT_EN
      , .retired(retired)
`endif
   );

   function automatic out_t sample();
      out_t s;
      s.pc_we = pc_we;     s.npc_sel = npc_sel;   s.ir_we = ir_we;
      s.reg_we = reg_we;   s.reg_dst = reg_dst;   s.wd_sel = wd_sel;
      s.alu_src = alu_src; s.alu_op = alu_op;     s.ext_op = ext_op;
      s.dmem_req = dmem_req; s.dmem_we = dmem_we; s.illegal = illegal;
      s.state = state;
      return s;
   endfunction

   function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'h00) return (fn == ADDU_FN) || (fn == SUBU_FN) || (fn == JR_FN);
      return op inside {ORI, LUI, LW, SW, BEQ, J, JAL};
   endfunction

   // Expected output per cycle of one instruction, from the instruction's semantics
   task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z, input int w);
      out_t e;
      logic rtype;
      rtype = (op == 6'h00);
      exp_q.delete();
      rdy_q.delete();
      e = '0; e.ir_we = 1'b1; e.pc_we = 1'b1; e.state = 3'd0;
      exp_q.push_back(e); rdy_q.push_back(1'($urandom_range(0, 1)));
      e = '0; e.state = 3'd1;
      if (!legal(op, fn)) begin
         e.illegal = 1'b1;
      end else if (op == J || op == JAL) begin
         e.pc_we = 1'b1; e.npc_sel = 2'b10;
         if (op == JAL) begin
            e.reg_we = 1'b1; e.reg_dst = 2'b10; e.wd_sel = 2'b10;
         end
      end else if (rtype && fn == JR_FN) begin
         e.pc_we = 1'b1; e.npc_sel = 2'b11;
      end
      exp_q.push_back(e); rdy_q.push_back(1'($urandom_range(0, 1)));
      if (!legal(op, fn) || op == J || op == JAL || (rtype && fn == JR_FN)) return;
      e = '0; e.state = 3'd2;
      if (rtype)          e.alu_op = (fn == SUBU_FN) ? 3'b001 : 3'b000;
      else if (op == ORI) begin e.alu_src = 1'b1; e.alu_op = 3'b010; end
      else if (op == LUI) begin e.alu_src = 1'b1; e.alu_op = 3'b011; end
      else if (op == LW || op == SW) begin e.alu_src = 1'b1; e.ext_op = 1'b1; end
      else if (op == BEQ) begin e.alu_op = 3'b001; e.npc_sel = 2'b01; e.pc_we = z; end
      exp_q.push_back(e); rdy_q.push_back(1'($urandom_range(0, 1)));
      if (op == BEQ) return;
      if (op == LW || op == SW) begin
         for (int i = 0; i <= w; i++) begin
            e.state = 3'd3; e.dmem_req = 1'b1; e.dmem_we = (op == SW);
            exp_q.push_back(e); rdy_q.push_back(i == w);
         end
         if (op == SW) return;
      end
      e.state = 3'd4; e.dmem_req = 1'b0; e.dmem_we = 1'b0; e.reg_we = 1'b1;
      e.reg_dst = rtype ? 2'b01 : 2'b00;
      e.wd_sel  = (op == LW) ? 2'b01 : 2'b00;
      exp_q.push_back(e); rdy_q.push_back(1'($urandom_range(0, 1)));
   endtask

   task automatic run_cycles(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int n, input string name);
      out_t got;
      for (int i = 0; i < n; i++) begin
         opcode = op; funct = fn; zero = z; dmem_ready = rdy_q[i];
         @(negedge clk);
         got = sample();
         checks++;
         if (got !== exp_q[i]) begin
            errors++;
            $display("FAIL %s cyc%0d got=%h exp=%h", name, i, got, exp_q[i]);
         end
`ifdef INSTR_CNT_EN
         if (i == 0) begin
            checks++;
            if (retired !== 32'(model_cnt)) begin
               errors++;
               $display("FAIL %s retired got=%0d exp=%0d", name, retired, model_cnt);
            end
         end
`endif
         @(posedge clk); #1;
      end
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int w, input string name);
      build(op, fn, z, w);
      run_cycles(op, fn, z, exp_q.size(), name);
      if (legal(op, fn)) model_cnt++;
   endtask

   task automatic test_reset();
      reset = 1'b1; opcode = 6'h3F; funct = 6'h00; zero = 1'b1; dmem_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (sample() !== out_t'(0)) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", sample());
         end
      end
`ifdef INSTR_CNT_EN
      checks++;
      if (retired !== 32'd0) begin
         errors++;
         $display("FAIL reset_retired got=%0d exp=0", retired);
      end
`endif
      @(posedge clk); #1;
      reset = 1'b0;
      model_cnt = 0;
      run_instr(6'h3F, 6'h00, 1'b0, 0, "post_reset_illegal");
   endtask

   task automatic test_alu();
      run_instr(6'h00, ADDU_FN, 1'b0, 0, "addu");
      run_instr(6'h00, SUBU_FN, 1'b1, 0, "subu");
      run_instr(ORI, 6'h15, 1'b0, 0, "ori");
      run_instr(LUI, 6'h3A, 1'b1, 0, "lui");
   endtask

   task automatic test_mem();
      run_instr(LW, 6'h00, 1'b0, 3, "lw_wait3");
      run_instr(LW, 6'h00, 1'b0, 0, "lw_nowait");
      run_instr(SW, 6'h00, 1'b1, 2, "sw_wait2");
   endtask

   task automatic test_branch_jump();
      run_instr(BEQ, 6'h00, 1'b1, 0, "beq_taken");
      run_instr(BEQ, 6'h00, 1'b0, 0, "beq_not_taken");
      run_instr(JAL, 6'h00, 1'b0, 0, "jal");
      run_instr(J, 6'h00, 1'b1, 0, "j");
      run_instr(6'h00, JR_FN, 1'b0, 0, "jr");
   endtask

   task automatic test_illegal();
      run_instr(6'h3F, 6'h21, 1'b0, 0, "illegal_op3f");
      run_instr(6'h00, 6'h20, 1'b0, 0, "illegal_funct");
      run_instr(6'h05, 6'h00, 1'b1, 0, "illegal_bne");
   endtask

   task automatic test_sw_reset();
      build(SW, 6'h00, 1'b0, 3);
      run_cycles(SW, 6'h00, 1'b0, 4, "sw_pre_reset");
      reset = 1'b1; dmem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b0 || sample() !== out_t'(0)) begin
         errors++;
         $display("FAIL sw_reset_mem got=%h exp=0", sample());
      end
      @(posedge clk); #1;
      reset = 1'b0;
      model_cnt = 0;
      run_instr(6'h00, ADDU_FN, 1'b0, 0, "after_sw_reset");
   endtask

   task automatic test_random();
      logic [5:0] ops [10] = '{6'h00, 6'h00, 6'h00, ORI, LUI, LW, SW, BEQ, J, JAL};
      logic [5:0] fns [3]  = '{ADDU_FN, SUBU_FN, JR_FN};
      logic [5:0] bad [4]  = '{6'h3F, 6'h05, 6'h08, 6'h2A};
      logic [5:0] op, fn;
      int k;
      for (int n = 0; n < 300; n++) begin
         k = int'($urandom_range(0, 10));
         fn = 6'($urandom);
         if (k == 10) begin
            op = bad[$urandom_range(0, 3)];
            if ($urandom_range(0, 1) == 1) begin
               op = 6'h00; fn = 6'h22;
            end
         end else begin
            op = ops[k];
            if (op == 6'h00) fn = fns[k];
         end
         run_instr(op, fn, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "random");
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mem();
      test_branch_jump();
      test_illegal();
      test_sw_reset();
      test_random();
      @(negedge clk);
      checks++;
      if (state !== 3'd0 || ir_we !== 1'b1) begin
         errors++;
         $display("FAIL final_fetch state=%0d ir_we=%b exp state=0 ir_we=1", state, ir_we);
      end
`ifdef INSTR_CNT_EN
      checks++;
      if (retired !== 32'(model_cnt)) begin
         errors++;
         $display("FAIL final_retired got=%0d exp=%0d", retired, model_cnt);
      end
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
